// File: rtl/ks10_bus_arb_if.sv
// Requester-side and backplane-side signal bundle of the KS10 bus arbiter.
interface ks10_bus_arb_if;
   logic [0:3]   reqREQI;
   logic [0:143] reqADDRI;
   logic [0:143] reqDATAI;
   logic [0:3]   reqACKO;
   logic [0:3]   reqNXMO;
   logic [0:3]   busGRANT;
   logic         busREQO;
   logic [0:35]  busADDRO;
   logic [0:35]  busDATAO;
   logic         busACKI;
   logic         busBUSY;

   modport master (
      input  reqREQI, reqADDRI, reqDATAI, busACKI,
      output reqACKO, reqNXMO, busGRANT, busREQO, busADDRO, busDATAO, busBUSY
   );

   modport slave (
      output reqREQI, reqADDRI, reqDATAI, busACKI,
      input  reqACKO, reqNXMO, busGRANT, busREQO, busADDRO, busDATAO, busBUSY
   );
endinterface

// File: rtl/ks10_bus_arb.sv
// KS10 backplane arbiter: console has fixed priority, CPU/UBA1/UBA3 rotate;
// one latched transaction at a time, completed by slave ack or timeout.
module ks10_bus_arb #(
   parameter int unsigned TIMEOUT = 63
) (
   input  logic           clk,
   input  logic           rst,
   ks10_bus_arb_if.master bus
);
   localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 32'd1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t       state_r;
   state_t       state_nxt_s;
   logic [1:0]   rr_last_r;
   logic [7:0]   timer_r;
   logic [0:3]   grant_r;
   logic [0:35]  addr_r;
   logic [0:35]  data_r;
   logic         req_r;
   logic         busy_r;
   logic [0:3]   ack_r;
   logic [0:3]   nxm_r;
   logic [1:0]   winner_s;
   logic         any_req_s;
   logic         timeout_s;
   logic         complete_s;

   // Next requester among 1..3 after 'last', wrapping 3 -> 1; 0 when none requests.
   function automatic logic [1:0] rr_pick(input logic [0:3] req, input logic [1:0] last);
      logic [1:0] cand;
      logic       found;
      rr_pick = 2'd0;
      found   = 1'b0;
      cand    = last;
      for (int k = 0; k < 3; k++) begin
         if (cand == 2'd3) begin
            cand = 2'd1;
         end else begin
            cand = cand + 2'd1;
         end
         if (!found && req[cand]) begin
            rr_pick = cand;
            found   = 1'b1;
         end else begin
            found = found;
         end
      end
   endfunction

   function automatic logic [0:35] slice36(input logic [0:143] v, input logic [1:0] idx);
      case (idx)
         2'd0:    slice36 = v[0:35];
         2'd1:    slice36 = v[36:71];
         2'd2:    slice36 = v[72:107];
         2'd3:    slice36 = v[108:143];
         default: slice36 = v[0:35];
      endcase
   endfunction

   // Winner selection and completion conditions.
   always_comb begin
      any_req_s  = |bus.reqREQI;
      winner_s   = 2'd0;
      if (bus.reqREQI[0]) begin
         winner_s = 2'd0;
      end else begin
         winner_s = rr_pick(bus.reqREQI, rr_last_r);
      end
      timeout_s  = (state_r == ST_WAIT) && !bus.busACKI && (timer_r == TIMEOUT_M1);
      complete_s = (state_r == ST_WAIT) && (bus.busACKI || (timer_r == TIMEOUT_M1));
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (any_req_s) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (complete_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Grant, latched bus values, timer and completion pulses; every output is a flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_r   <= 4'b0000;
         addr_r    <= 36'd0;
         data_r    <= 36'd0;
         timer_r   <= 8'd0;
         rr_last_r <= 2'd3;
         req_r     <= 1'b0;
         busy_r    <= 1'b0;
         ack_r     <= 4'b0000;
         nxm_r     <= 4'b0000;
      end else begin
         ack_r <= 4'b0000;
         nxm_r <= 4'b0000;
         case (state_r)
            ST_IDLE: begin
               if (any_req_s) begin
                  grant_r <= 4'b1000 >> winner_s;
                  addr_r  <= slice36(bus.reqADDRI, winner_s);
                  data_r  <= slice36(bus.reqDATAI, winner_s);
                  timer_r <= 8'd0;
                  req_r   <= 1'b1;
                  busy_r  <= 1'b1;
                  if (winner_s != 2'd0) begin
                     rr_last_r <= winner_s;
                  end
               end
            end
            ST_WAIT: begin
               if (complete_s) begin
                  req_r <= 1'b0;
                  ack_r <= grant_r;
                  nxm_r <= timeout_s ? grant_r : 4'b0000;
               end else begin
                  timer_r <= timer_r + 8'd1;
               end
            end
            ST_DONE: begin
               grant_r <= 4'b0000;
               addr_r  <= 36'd0;
               data_r  <= 36'd0;
               busy_r  <= 1'b0;
            end
            default: begin
               grant_r <= 4'b0000;
               addr_r  <= 36'd0;
               data_r  <= 36'd0;
               req_r   <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busGRANT = grant_r;
   assign bus.busADDRO = addr_r;
   assign bus.busDATAO = data_r;
   assign bus.busREQO  = req_r;
   assign bus.busBUSY  = busy_r;
   assign bus.reqACKO  = ack_r;
   assign bus.reqNXMO  = nxm_r;
endmodule
